// File: rtl/inst_sram_resp.sv
`default_nettype none
// ============================================================================
// Module   : inst_sram_resp
// Brief    : Single-cycle instruction SRAM model with loader port, window and
//            alignment checking, sticky error capture and read counter.
// Revision : 1.0
// ============================================================================
module inst_sram_resp #(
    parameter int          ADDR_W = 12,
    parameter logic [31:0] BASE   = 32'h1C00_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_sram_en,
    input  logic [3:0]        inst_sram_we,
    input  logic [31:0]       inst_sram_addr,
    input  logic [31:0]       inst_sram_wdata,
    output logic [31:0]       inst_sram_rdata,
    input  logic              init_we,
    input  logic [ADDR_W-1:0] init_idx,
    input  logic [31:0]       init_wdata,
    output logic              err_flag,
    output logic [31:0]       err_addr,
    output logic [31:0]       rd_cnt
);

    localparam int c_DEPTH = 1 << ADDR_W;

    logic [31:0]       r_mem [c_DEPTH];

    logic [31:0]       r_rdata_q,    w_rdata_d;
    logic              r_err_flag_q, w_err_flag_d;
    logic [31:0]       r_err_addr_q, w_err_addr_d;
    logic [31:0]       r_rd_cnt_q,   w_rd_cnt_d;

    logic              w_in_win;
    logic [ADDR_W-1:0] w_idx;
    logic              w_acc;
    logic              w_rd;
    logic              w_wr;
    logic              w_err;
    logic              w_init_hit;

    assign w_in_win   = (inst_sram_addr[31:ADDR_W+2] == BASE[31:ADDR_W+2]) &&
                        (inst_sram_addr[1:0] == 2'b00);
    assign w_idx      = inst_sram_addr[ADDR_W+1:2];
    // Accesses presented while reset is high are discarded entirely.
    assign w_acc      = inst_sram_en && !reset;
    assign w_rd       = w_acc && w_in_win && (inst_sram_we == 4'b0000);
    assign w_wr       = w_acc && w_in_win && (inst_sram_we != 4'b0000);
    assign w_err      = w_acc && !w_in_win;
    assign w_init_hit = init_we && (init_idx == w_idx);

    always_comb begin
        w_rdata_d    = r_rdata_q;
        w_err_flag_d = r_err_flag_q;
        w_err_addr_d = r_err_addr_q;
        w_rd_cnt_d   = r_rd_cnt_q;

        // Reads and writes both return the pre-write word (read-first).
        if (w_acc) begin
            w_rdata_d = w_in_win ? r_mem[w_idx] : 32'h0;
        end

        if (w_err) begin
            w_err_flag_d = 1'b1;
            if (!r_err_flag_q) begin
                w_err_addr_d = inst_sram_addr;
            end
        end

        if (w_rd && (r_rd_cnt_q != 32'hFFFF_FFFF)) begin
            w_rd_cnt_d = r_rd_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata_q    <= 32'h0;
            r_err_flag_q <= 1'b0;
            r_err_addr_q <= 32'h0;
            r_rd_cnt_q   <= 32'h0;
        end else begin
            r_rdata_q    <= w_rdata_d;
            r_err_flag_q <= w_err_flag_d;
            r_err_addr_q <= w_err_addr_d;
            r_rd_cnt_q   <= w_rd_cnt_d;
        end
    end

    // Memory has no reset; the loader overrides a colliding port write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_wr && !w_init_hit) begin
                for (int i = 0; i < 4; i++) begin
                    if (inst_sram_we[i]) begin
                        r_mem[w_idx][8*i +: 8] <= inst_sram_wdata[8*i +: 8];
                    end
                end
            end
            if (init_we) begin
                r_mem[init_idx] <= init_wdata;
            end
        end
    end

    assign inst_sram_rdata = r_rdata_q;
    assign err_flag        = r_err_flag_q;
    assign err_addr        = r_err_addr_q;
    assign rd_cnt          = r_rd_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_sram_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_sram_resp
// Brief    : Directed scoreboard bench for inst_sram_resp.
// Revision : 1.0
// ============================================================================
module tb_inst_sram_resp;

    localparam int c_ADDR_W = 12;

    logic                clk;
    logic                reset;
    logic                inst_sram_en;
    logic [3:0]          inst_sram_we;
    logic [31:0]         inst_sram_addr;
    logic [31:0]         inst_sram_wdata;
    logic [31:0]         inst_sram_rdata;
    logic                init_we;
    logic [c_ADDR_W-1:0] init_idx;
    logic [31:0]         init_wdata;
    logic                err_flag;
    logic [31:0]         err_addr;
    logic [31:0]         rd_cnt;

    inst_sram_resp #(
        .ADDR_W (c_ADDR_W),
        .BASE   (32'h1C00_0000)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .init_we         (init_we),
        .init_idx        (init_idx),
        .init_wdata      (init_wdata),
        .err_flag        (err_flag),
        .err_addr        (err_addr),
        .rd_cnt          (rd_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          cr;
        logic [31:0] rd;
        bit          cc;
        logic [31:0] cnt;
        bit          ce;
        logic        ef;
        logic [31:0] ea;
        string       nm;
    } exp_t;

    exp_t exp_q[$];
    exp_t nxt;
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic set_exp(input logic [31:0] rd, input logic [31:0] cnt,
                           input logic ef, input logic [31:0] ea, input string nm);
        nxt.cr  = 1'b1; nxt.rd  = rd;
        nxt.cc  = 1'b1; nxt.cnt = cnt;
        nxt.ce  = 1'b1; nxt.ef  = ef; nxt.ea = ea;
        nxt.nm  = nm;
    endtask

    // Drives one cycle of stimulus and queues the response expected after the edge.
    task automatic cyc(input logic rst, input logic en, input logic [3:0] we,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic iwe, input logic [c_ADDR_W-1:0] iidx,
                       input logic [31:0] iwd);
        reset           = rst;
        inst_sram_en    = en;
        inst_sram_we    = we;
        inst_sram_addr  = addr;
        inst_sram_wdata = wd;
        init_we         = iwe;
        init_idx        = iidx;
        init_wdata      = iwd;
        exp_q.push_back(nxt);
        nxt.cr = 1'b0; nxt.cc = 1'b0; nxt.ce = 1'b0; nxt.nm = "idle";
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a);
        cyc(1'b0, 1'b1, 4'h0, a, 32'h0, 1'b0, '0, 32'h0);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, '0, 32'h0);
    endtask

    task automatic load(input logic [c_ADDR_W-1:0] i, input logic [31:0] d);
        cyc(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, i, d);
    endtask

    // Monitor: the entry queued before an edge is checked at the following negedge.
    initial begin : mon
        exp_t e;
        forever begin
            @(posedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                @(negedge clk);
                if (e.cr) begin
                    n_total++;
                    if (inst_sram_rdata === e.rd) n_pass++;
                    else $display("FAIL %s rdata: got %h expected %h", e.nm, inst_sram_rdata, e.rd);
                end
                if (e.cc) begin
                    n_total++;
                    if (rd_cnt === e.cnt) n_pass++;
                    else $display("FAIL %s rd_cnt: got %0d expected %0d", e.nm, rd_cnt, e.cnt);
                end
                if (e.ce) begin
                    n_total++;
                    if (err_flag === e.ef && err_addr === e.ea) n_pass++;
                    else $display("FAIL %s err: got flag=%b addr=%h expected flag=%b addr=%h",
                                  e.nm, err_flag, err_addr, e.ef, e.ea);
                end
            end
        end
    end

    initial begin : stim
        nxt.cr = 1'b0; nxt.cc = 1'b0; nxt.ce = 1'b0; nxt.nm = "idle";

        // Reset with an access presented: discarded.
        set_exp(32'h0, 32'd0, 1'b0, 32'h0, "reset0");
        cyc(1'b1, 1'b1, 4'h0, 32'h1C00_0000, 32'h0, 1'b0, '0, 32'h0);
        set_exp(32'h0, 32'd0, 1'b0, 32'h0, "reset1");
        cyc(1'b1, 1'b1, 4'h0, 32'h1C00_0000, 32'h0, 1'b0, '0, 32'h0);

        set_exp(32'h0, 32'd0, 1'b0, 32'h0, "load0");
        load(12'd0, 32'h0280_0401);
        load(12'd1, 32'h1234_5678);
        load(12'd2, 32'h0000_00A5);

        set_exp(32'h0280_0401, 32'd1, 1'b0, 32'h0, "rd0");
        rd(32'h1C00_0000);
        set_exp(32'h1234_5678, 32'd2, 1'b0, 32'h0, "rd1_b2b");
        rd(32'h1C00_0004);
        set_exp(32'h1234_5678, 32'd3, 1'b0, 32'h0, "rd1_again");
        rd(32'h1C00_0004);
        for (int k = 0; k < 5; k++) begin
            set_exp(32'h1234_5678, 32'd3, 1'b0, 32'h0, "hold");
            idle();
        end

        set_exp(32'h1234_5678, 32'd3, 1'b0, 32'h0, "wr_readfirst");
        cyc(1'b0, 1'b1, 4'b0101, 32'h1C00_0004, 32'hAABB_CCDD, 1'b0, '0, 32'h0);
        set_exp(32'h12BB_56DD, 32'd4, 1'b0, 32'h0, "rd_after_wr");
        rd(32'h1C00_0004);

        set_exp(32'h0, 32'd4, 1'b1, 32'h1BFF_FFFC, "err_below");
        rd(32'h1BFF_FFFC);
        set_exp(32'h0, 32'd4, 1'b1, 32'h1BFF_FFFC, "err_misalign");
        rd(32'h1C00_0002);
        set_exp(32'h0, 32'd4, 1'b1, 32'h1BFF_FFFC, "err_wr_above");
        cyc(1'b0, 1'b1, 4'hF, 32'h1C00_4000, 32'hFFFF_FFFF, 1'b0, '0, 32'h0);

        set_exp(32'h12BB_56DD, 32'd4, 1'b1, 32'h1BFF_FFFC, "init_vs_wr");
        cyc(1'b0, 1'b1, 4'hF, 32'h1C00_0004, 32'h2222_2222, 1'b1, 12'd1, 32'h1111_1111);
        set_exp(32'h1111_1111, 32'd5, 1'b1, 32'h1BFF_FFFC, "init_wins");
        rd(32'h1C00_0004);

        set_exp(32'h0000_00A5, 32'd6, 1'b1, 32'h1BFF_FFFC, "init_vs_rd_old");
        cyc(1'b0, 1'b1, 4'h0, 32'h1C00_0008, 32'h0, 1'b1, 12'd2, 32'hCAFE_F00D);
        set_exp(32'hCAFE_F00D, 32'd7, 1'b1, 32'h1BFF_FFFC, "init_vs_rd_new");
        rd(32'h1C00_0008);
        set_exp(32'h0280_0401, 32'd8, 1'b1, 32'h1BFF_FFFC, "mem0_intact");
        rd(32'h1C00_0000);

        // Reset mid-stream; its port and loader writes must be dropped.
        set_exp(32'h0, 32'd0, 1'b0, 32'h0, "reset_mid");
        cyc(1'b1, 1'b1, 4'hF, 32'h1C00_0000, 32'hDEAD_BEEF, 1'b1, 12'd0, 32'hBAD0_BAD0);
        set_exp(32'h0280_0401, 32'd1, 1'b0, 32'h0, "post_reset_rd0");
        rd(32'h1C00_0000);
        set_exp(32'h1111_1111, 32'd2, 1'b0, 32'h0, "post_reset_rd1");
        rd(32'h1C00_0004);
        set_exp(32'h1111_1111, 32'd2, 1'b0, 32'h0, "final_hold");
        idle();

        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inst_sram_resp.md
INST_SRAM_RESP -- requirements
Module: inst_sram_resp

Interface
REQ-001 Parameter ADDR_W, default 12, word-index width; memory depth 2^ADDR_W 32-bit words.
REQ-002 Parameter BASE, default 32'h1C00_0000, byte base address of the memory window; low ADDR_W+2 bits SHALL be zero.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 inst_sram_en  input  1  access request; one access per cycle when high.
REQ-006 inst_sram_we  input  4  byte write enables; 4'b0 means read.
REQ-007 inst_sram_addr  input  32  byte address of access.
REQ-008 inst_sram_wdata  input  32  write data, byte lane i = bits 8i+7:8i.
REQ-009 inst_sram_rdata  output  32  registered read data for the previous accepted access.
REQ-010 init_we  input  1  bench/loader word write strobe.
REQ-011 init_idx  input  ADDR_W  loader word index.
REQ-012 init_wdata  input  32  loader write data.
REQ-013 err_flag  output  1  sticky: an out-of-window or misaligned access occurred.
REQ-014 err_addr  output  32  address of the first erroneous access since reset.
REQ-015 rd_cnt  output  32  count of accepted in-window read accesses.

Function
REQ-016 In-window SHALL mean addr[31:ADDR_W+2] == BASE[31:ADDR_W+2] and addr[1:0] == 2'b00; idx = addr[ADDR_W+1:2].
REQ-017 Read (en=1, we=0, in-window): rdata SHALL equal mem[idx] exactly one cycle later (latency 1, no wait states).
REQ-018 Write (en=1, we!=0, in-window): each lane with we[i]=1 SHALL be updated from wdata; other lanes unchanged.
REQ-019 Write access SHALL also return old (pre-write) mem[idx] on rdata next cycle (read-first).
REQ-020 en=0: rdata SHALL hold its previous value indefinitely; no memory or counter change.
REQ-021 Out-of-window or misaligned access with en=1: no memory write; rdata next cycle SHALL be 32'h0; err_flag SHALL set.
REQ-022 err_addr SHALL capture addr only on the access that first sets err_flag; later errors do not overwrite it.
REQ-023 rd_cnt SHALL increment by 1 per in-window read (we=0), saturating at 32'hFFFF_FFFF; writes and errors not counted.
REQ-024 init_we=1: mem[init_idx] <= init_wdata, full word, independent of en.
REQ-025 Same-cycle init_we and port write to the same idx: init write SHALL win for all lanes; port write dropped.
REQ-026 Same-cycle init_we and port read of the same idx: rdata SHALL return the old word; new word visible from the following read.
REQ-027 Back-to-back reads every cycle SHALL each return their own data one cycle later; no bubble required.

Reset
REQ-028 With reset=1 at a posedge: rdata <= 32'h0, err_flag <= 0, err_addr <= 32'h0, rd_cnt <= 32'h0.
REQ-029 Memory contents SHALL NOT be cleared by reset; port and init writes SHALL be suppressed in any cycle with reset=1.
REQ-030 An access presented in a reset cycle SHALL be discarded: not counted, no error, rdata 32'h0 next cycle.
REQ-031 First access SHALL be accepted in the first cycle with reset=0.

Verification
REQ-032 Load mem[0]=32'h0280_0401, mem[1]=32'h1234_5678 via init; read 0x1C00_0000 then 0x1C00_0004 consecutively -> rdata 0x0280_0401 then 0x1234_5678 on successive cycles; rd_cnt=2.
REQ-033 Read 0x1C00_0004, then en=0 for 5 cycles -> rdata stays 0x1234_5678 all 5 cycles; rd_cnt unchanged.
REQ-034 Write we=4'b0101, wdata=32'hAABB_CCDD to 0x1C00_0004 -> rdata next cycle 0x1234_5678; subsequent read -> 0x12BB_56DD.
REQ-035 Read 0x1BFF_FFFC, then 0x1C00_0002 -> rdata 0 each, err_flag=1, err_addr=0x1BFF_FFFC; rd_cnt not incremented.
REQ-036 Same cycle: init_we to idx 1 with 32'h1111_1111 and port write 32'h2222_2222 to 0x1C00_0004 -> later read returns 0x1111_1111.
REQ-037 Assert reset during a read stream -> rdata 0, err_flag 0, rd_cnt 0 next cycle; mem[0] still 0x0280_0401 on post-reset read.
